// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the stall/flush scheduler.
// Used by pipeline_stall_scheduler and mdu_occupancy_counter.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      SCHED_RUN      = 2'd0,
      SCHED_MDU_BUSY = 2'd1
   } sched_state_t;

   localparam logic [4:0] REG_ZERO           = 5'd0;
   localparam int         MDU_CYCLES_DEFAULT = 32;

   // A load into $zero never produces a real value, so it can never create a hazard.
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != REG_ZERO) && (dst == src);
   endfunction

endpackage

// File: rtl/mdu_occupancy_counter.sv
// Down-counter that tracks how many EX cycles remain for an in-flight mult/div.
// It holds at zero, and the zero flag marks the final busy cycle.
module mdu_occupancy_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pipeline_stall_scheduler.sv
// Central stall/flush scheduler for the 5-stage MIPS pipeline: branch flush, load-use stall, MDU stall.
// Optional build macro PIPE_SCHED_PERF_CNT_EN adds the stall_cycles/flush_count counters.
module pipeline_stall_scheduler
   import pipe_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES = MDU_CYCLES_DEFAULT,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_RtAddr,
   input  logic [4:0]  IF_ID_RsAddr,
   input  logic [4:0]  IF_ID_RtAddr,
   input  logic        IF_ID_UsesRt,
   input  logic        ID_MduStart,
   input  logic        ID_ReadsHiLo,
   input  logic        EX_BranchTaken,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Bubble,
   output logic        mdu_busy,
   output logic [1:0]  sched_state
`ifdef PIPE_SCHED_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

   sched_state_t state;
   logic         luh;
   logic         mduc;
   logic         mdu_issue;
   logic         cnt_zero;

   assign luh = ID_EX_MemRead &&
                (reg_match(ID_EX_RtAddr, IF_ID_RsAddr) ||
                 (IF_ID_UsesRt && reg_match(ID_EX_RtAddr, IF_ID_RtAddr)));

   assign mduc = (state == SCHED_MDU_BUSY) && (ID_MduStart || ID_ReadsHiLo);

   // A branch squashes the ID instruction, so a squashed mult/div must never start the MDU.
   assign mdu_issue = (state == SCHED_RUN) && ID_MduStart && !EX_BranchTaken && !luh;

   mdu_occupancy_counter #(
      .CNT_W (CNT_W)
   ) u_mdu_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (mdu_issue),
      .load_value (MDU_LOAD),
      .enable     (state == SCHED_MDU_BUSY),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SCHED_RUN;
         mdu_busy <= 1'b0;
      end else begin
         case (state)
            SCHED_RUN: begin
               if (mdu_issue) begin
                  state    <= SCHED_MDU_BUSY;
                  mdu_busy <= 1'b1;
               end
            end
            SCHED_MDU_BUSY: begin
               // The count keeps running through branch flushes; the operation was already issued.
               if (cnt_zero) begin
                  state    <= SCHED_RUN;
                  mdu_busy <= 1'b0;
               end
            end
            default: begin
               state    <= SCHED_RUN;
               mdu_busy <= 1'b0;
            end
         endcase
      end
   end

   assign sched_state = state;

   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      if (!rst_n) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (EX_BranchTaken) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (luh || mduc) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

`ifdef PIPE_SCHED_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!PCWrite && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (IF_ID_Flush && (flush_count != 32'hFFFF_FFFF)) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_stall_scheduler.sv
// Scoreboard bench for pipeline_stall_scheduler (MDU_CYCLES=4); directed vectors with hand-computed outputs.
// Checks the optional counters too when PIPE_SCHED_PERF_CNT_EN is defined.
module tb_pipeline_stall_scheduler;

   // Expected vector: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, mdu_busy, sched_state[1:0]}
   localparam logic [6:0] E_RST   = 7'b0011_0_00;
   localparam logic [6:0] E_DEF   = 7'b1100_0_00;
   localparam logic [6:0] E_STALL = 7'b0001_0_00;
   localparam logic [6:0] E_FLUSH = 7'b1111_0_00;
   localparam logic [6:0] E_BDEF  = 7'b1100_1_01;
   localparam logic [6:0] E_BSTL  = 7'b0001_1_01;
   localparam logic [6:0] E_BFLS  = 7'b1111_1_01;

   logic       clk;
   logic       rst_n;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_RtAddr;
   logic [4:0] IF_ID_RsAddr;
   logic [4:0] IF_ID_RtAddr;
   logic       IF_ID_UsesRt;
   logic       ID_MduStart;
   logic       ID_ReadsHiLo;
   logic       EX_BranchTaken;
   logic       PCWrite;
   logic       IF_ID_Write;
   logic       IF_ID_Flush;
   logic       ID_EX_Bubble;
   logic       mdu_busy;
   logic [1:0] sched_state;
`ifdef PIPE_SCHED_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   logic [6:0] exp_q[$];
   string      name_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [6:0] mon_exp;
   logic [6:0] mon_got;
   string      mon_name;

   pipeline_stall_scheduler #(
      .MDU_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_EX_RtAddr   (ID_EX_RtAddr),
      .IF_ID_RsAddr   (IF_ID_RsAddr),
      .IF_ID_RtAddr   (IF_ID_RtAddr),
      .IF_ID_UsesRt   (IF_ID_UsesRt),
      .ID_MduStart    (ID_MduStart),
      .ID_ReadsHiLo   (ID_ReadsHiLo),
      .EX_BranchTaken (EX_BranchTaken),
      .PCWrite        (PCWrite),
      .IF_ID_Write    (IF_ID_Write),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Bubble   (ID_EX_Bubble),
      .mdu_busy       (mdu_busy),
      .sched_state    (sched_state)
`ifdef PIPE_SCHED_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
`endif
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // Driver: apply one cycle of inputs and queue the response expected in that cycle
   task automatic step(input string name, input logic mr, input logic [4:0] ex_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic start, input logic hilo, input logic br,
                       input logic [6:0] exp);
      ID_EX_MemRead  = mr;
      ID_EX_RtAddr   = ex_rt;
      IF_ID_RsAddr   = rs;
      IF_ID_RtAddr   = rt;
      IF_ID_UsesRt   = uses_rt;
      ID_MduStart    = start;
      ID_ReadsHiLo   = hilo;
      EX_BranchTaken = br;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string name, input logic [6:0] exp);
      step(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
   endtask

   // Monitor / scoreboard: outputs are valid every cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_got  = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, mdu_busy, sched_state};
         n_cmp++;
         if (mon_got !== mon_exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b (PCW,IFW,FL,BUB,BUSY,ST)", mon_name, mon_got, mon_exp);
         end
      end
   end

   initial begin
      logic [4:0] r_rs;
      logic [4:0] r_rt;
      rst_n = 1'b0;
      ID_EX_MemRead = 1'b0; ID_EX_RtAddr = '0; IF_ID_RsAddr = '0; IF_ID_RtAddr = '0;
      IF_ID_UsesRt = 1'b0; ID_MduStart = 1'b0; ID_ReadsHiLo = 1'b0; EX_BranchTaken = 1'b0;
      @(posedge clk);
      #1;

      idle("reset_0", E_RST);
      idle("reset_1", E_RST);
      rst_n = 1'b1;
      idle("post_reset_default", E_DEF);

      // Load-use on rs, then release
      step("luh_rs", 1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
      step("luh_rs_release", 1'b0, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      step("luh_rt", 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, E_STALL);
      step("luh_zero_reg", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_DEF);
      step("luh_rt_unused", 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      for (int i = 0; i < 4; i++) begin
         r_rs = 5'($urandom_range(9, 31));
         r_rt = 5'($urandom_range(9, 31));
         step("luh_no_match", 1'b1, 5'd8, r_rs, r_rt, 1'b1, 1'b0, 1'b0, 1'b0, E_DEF);
      end

      // MDU issue at t, HI/LO read held from t+1: stalled t+1..t+4, released t+5
      step("mdu_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_DEF);
      for (int i = 0; i < 4; i++) begin
         step("mdu_hilo_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_BSTL);
      end
      step("mdu_hilo_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_DEF);

      // Independent work, branch while busy, back-to-back mult/div
      step("mdu_issue2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_DEF);
      step("busy_indep", 1'b0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E_BDEF);
      step("busy_branch", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_BFLS);
      step("busy_start_stall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BSTL);
      step("busy_last_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BSTL);
      step("reissue_run", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_DEF);
      for (int i = 0; i < 4; i++) begin
         idle("reissue_busy", E_BDEF);
      end
      idle("reissue_done", E_DEF);

      // Branch outranks load-use and MDU start; MDU must not be issued
      step("branch_priority", 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, E_FLUSH);
      idle("branch_no_issue", E_DEF);

      // Reset in busy cycle 2
      step("rst_mid_issue", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_DEF);
      idle("rst_mid_busy1", E_BDEF);
      rst_n = 1'b0;
      step("rst_mid_asserted", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RST);
      rst_n = 1'b1;
      step("rst_mid_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_DEF);
      idle("rst_mid_after", E_DEF);

`ifdef PIPE_SCHED_PERF_CNT_EN
      rst_n = 1'b0;
      idle("perf_reset", E_RST);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("perf_luh", 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
      end
      for (int i = 0; i < 2; i++) begin
         step("perf_flush", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_FLUSH);
      end
      idle("perf_idle", E_DEF);
      n_cmp++;
      if (stall_cycles !== 32'd3) begin
         n_bad++;
         $display("FAIL perf_stall_cycles: got %0d required 3", stall_cycles);
      end
      n_cmp++;
      if (flush_count !== 32'd2) begin
         n_bad++;
         $display("FAIL perf_flush_count: got %0d required 2", flush_count);
      end
`endif

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_scheduler.md
Name: pipeline_stall_scheduler

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Arbitrates three stall/flush sources, highest priority first:
  - EX-stage taken-branch flush
  - load-use hazard stall
  - multi-cycle multiply/divide unit (MDU) occupancy stall
- Drives PC, IF/ID and ID/EX control enables from one place.
- Tracks the MDU with an internal state machine and down-counter; no MDU done handshake is required.

Parameters:
- MDU_CYCLES, 32, EX-occupancy cycles of one mult/div, legal range 1..255.
- CNT_W, 8, MDU down-counter width; must satisfy 2^CNT_W > MDU_CYCLES.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_RtAddr  input  5  load destination register.
- IF_ID_RsAddr  input  5  rs of instruction in ID.
- IF_ID_RtAddr  input  5  rt of instruction in ID.
- IF_ID_UsesRt  input  1  ID instruction reads rt as a source.
- ID_MduStart  input  1  ID instruction is mult/multu/div/divu.
- ID_ReadsHiLo  input  1  ID instruction is mfhi/mflo.
- EX_BranchTaken  input  1  branch/jump in EX resolved taken.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register write enable; 1 = load.
- IF_ID_Flush  output  1  zero the IF/ID register.
- ID_EX_Bubble  output  1  force ID/EX controls to NOP.
- mdu_busy  output  1  MDU occupied.
- sched_state  output  2  current FSM state, for debug.

Behaviour:
- States:
  - RUN = 2'd0, MDU_BUSY = 2'd1.
  - Encoding 2'd2/2'd3 unused; on entry to an unused state, go to RUN next cycle.
- Reset:
  - rst_n low asynchronously sets state RUN and counter 0.
  - While rst_n is low: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, mdu_busy=0.
- All enable/flush outputs are combinational from state and inputs, valid in the same cycle (zero latency).
- Default (no event): PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
- Load-use hazard (luh) is true when all of:
  - ID_EX_MemRead=1
  - ID_EX_RtAddr!=0
  - (ID_EX_RtAddr==IF_ID_RsAddr) or (IF_ID_UsesRt and ID_EX_RtAddr==IF_ID_RtAddr)
- MDU conflict (mduc) is true when: state==MDU_BUSY and (ID_MduStart or ID_ReadsHiLo).
- Priority 1, EX_BranchTaken=1:
  - PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1.
  - luh, mduc and ID_MduStart are ignored (ID is squashed).
- Priority 2, luh:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - ID_MduStart is not issued this cycle.
- Priority 3, mduc: same outputs as luh.
- Issue: in RUN, ID_MduStart=1 with no branch and no luh:
  - Instruction advances.
  - Next state MDU_BUSY; counter loads MDU_CYCLES-1.
- MDU_BUSY:
  - Counter decrements each cycle.
  - When counter==0, next state is RUN; mdu_busy=1 for exactly MDU_CYCLES cycles.
  - MDU_CYCLES=1 gives a single busy cycle.
  - ID_MduStart seen in the last busy cycle is stalled that cycle and issues from RUN on the following cycle.
- EX_BranchTaken while MDU_BUSY:
  - Flush as above; MDU keeps counting (the operation was issued before the branch).
- Independent instructions proceed unstalled during MDU_BUSY.
- Mid-operation reset:
  - Counter and state clear immediately.
  - No stall persists after rst_n rises.

Optional Feature:
- Macro: PIPE_SCHED_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles[31:0] (cycles with PCWrite=0 and rst_n high) and flush_count[31:0] (cycles with IF_ID_Flush=1 and rst_n high).
  - Both counters saturate at 32'hFFFFFFFF and are cleared by rst_n.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - State localparams SCHED_RUN and SCHED_MDU_BUSY
  - REG_ZERO = 5'd0
  - Default MDU_CYCLES constant
- Sub-module mdu_occupancy_counter:
  - Inputs: load, load_value, enable.
  - Output: zero flag.
  - Instantiated once.
- Priority/hazard compare logic stays in the top module.

Test Plan:
- Load-use on rs:
  - Stimulus: MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8.
  - Response: PCWrite=0, IF_ID_Write=0, Bubble=1 for one cycle; defaults the next cycle once MemRead=0.
- $zero and unused-rt:
  - Stimulus: ID_EX_Rt=0 matching Rs → no stall. ID_EX_Rt=9, IF_ID_Rt=9, UsesRt=0 → no stall.
- MDU issue, MDU_CYCLES=4:
  - Stimulus: ID_MduStart at cycle t.
  - Response: mdu_busy=1 in cycles t+1..t+4. ID_ReadsHiLo held from t+1 → stalled through t+4, released at t+5.
- Branch priority:
  - Stimulus: EX_BranchTaken=1 with luh=1 and ID_MduStart=1 simultaneously.
  - Response: Flush=1, Bubble=1, PCWrite=1; state stays RUN.
- Reset mid-MDU:
  - Stimulus: rst_n low at busy cycle 2 of 32.
  - Response: mdu_busy=0 immediately; after release, state=RUN and no stall.
- With PIPE_SCHED_PERF_CNT_EN:
  - Stimulus: 3 load-use stalls and 2 flushes.
  - Response: stall_cycles=3, flush_count=2.
